// File: rtl/dff_compare_monitor.sv
// dff_compare_monitor
// On-board checker for two flip-flop implementations driven by the same stimulus.
// Every RUN cycle it compares the Q and Qbar outputs of both implementations.
// It also checks that each implementation's outputs are true complements.
// It keeps sticky error flags, a saturating error count, a saturating count of
// compared cycles, and the index of the first failing cycle.
// It finishes in DONE with a pass/fail verdict.

module dff_compare_monitor #(
    parameter int CNT_W        = 16,
    parameter int ERR_W        = 8,
    parameter int HOLDOFF      = 2,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             q_a,
    input  logic             qb_a,
    input  logic             q_b,
    input  logic             qb_b,
    output logic [1:0]       state,
    output logic             err_q,
    output logic             err_qb,
    output logic             err_comp,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_fail_cycle,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HOLD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // The holdoff counter only needs to hold values from 0 up to HOLDOFF.
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);

    state_t            cur_state;
    state_t            nxt_state;
    logic [HOLD_W-1:0] hold_cnt;

    // Next values of the registered datapath.
    logic [HOLD_W-1:0] nxt_hold;
    logic              nxt_err_q;
    logic              nxt_err_qb;
    logic              nxt_err_comp;
    logic [ERR_W-1:0]  nxt_err_cnt;
    logic [CNT_W-1:0]  nxt_ffc;
    logic [CNT_W-1:0]  nxt_cycle;
    logic              nxt_done;
    logic              nxt_pass;

    // Comparison terms use the input values present just before the edge.
    logic mq;
    logic mqb;
    logic mc;
    logic fail;

    assign mq   = q_a ^ q_b;
    assign mqb  = qb_a ^ qb_b;
    assign mc   = ~(q_a ^ qb_a) | ~(q_b ^ qb_b);
    assign fail = mq | mqb | mc;

    assign state = cur_state;

    // State register: synchronous active-low reset returns the checker to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples the pre-edge value of the others.
        if (!rst) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic. start wins over stop and over a mismatch in the same cycle.
    always_comb begin
        // NOTE: default first so no path through the case leaves a latch.
        nxt_state = cur_state;
        if (start) begin
            nxt_state = (HOLDOFF == 0) ? S_RUN : S_HOLD;
        end else begin
            case (cur_state)
                S_HOLD: begin
                    // Leave HOLD on the edge where the counter reads 1.
                    // That edge ends exactly HOLDOFF cycles spent in HOLD.
                    if (hold_cnt <= HOLD_ONE) begin
                        nxt_state = S_RUN;
                    end
                end
                S_RUN: begin
                    // The compare for this edge still happens; DONE is entered afterwards.
                    if (stop || (fail && (STOP_ON_FAIL != 0))) begin
                        nxt_state = S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE are left only by start or reset; stop is ignored.
                end
            endcase
        end
    end

    // Output/datapath next-value logic: counters, sticky flags and the verdict.
    always_comb begin
        nxt_hold     = hold_cnt;
        nxt_err_q    = err_q;
        nxt_err_qb   = err_qb;
        nxt_err_comp = err_comp;
        nxt_err_cnt  = err_cnt;
        nxt_ffc      = first_fail_cycle;
        nxt_cycle    = cycle_cnt;

        if (start) begin
            // A new run discards every result of the previous run.
            nxt_hold     = HOLD_INIT;
            nxt_err_q    = 1'b0;
            nxt_err_qb   = 1'b0;
            nxt_err_comp = 1'b0;
            nxt_err_cnt  = '0;
            nxt_ffc      = '0;
            nxt_cycle    = '0;
        end else begin
            case (cur_state)
                S_HOLD: begin
                    if (hold_cnt != '0) begin
                        nxt_hold = hold_cnt - HOLD_ONE;
                    end
                end
                S_RUN: begin
                    // Once saturated, cycle_cnt stays at all-ones while comparisons continue.
                    if (cycle_cnt != CNT_MAX) begin
                        nxt_cycle = cycle_cnt + CNT_ONE;
                    end
                    if (fail) begin
                        nxt_err_q    = err_q | mq;
                        nxt_err_qb   = err_qb | mqb;
                        nxt_err_comp = err_comp | mc;
                        if (err_cnt != ERR_MAX) begin
                            nxt_err_cnt = err_cnt + ERR_ONE;
                        end
                        // A zero count means this is the first failure of the run.
                        // The index recorded is the 0-based cycle number before it increments.
                        if (err_cnt == '0) begin
                            nxt_ffc = cycle_cnt;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold every result.
                end
            endcase
        end

        // done and pass are registered from the next state.
        // This lets the verdict appear on the same edge that enters DONE.
        nxt_done = (nxt_state == S_DONE);
        nxt_pass = (nxt_state == S_DONE) && (nxt_err_cnt == '0);
    end

    // Datapath registers. A reset clears everything, including a run in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt         <= '0;
            err_q            <= 1'b0;
            err_qb           <= 1'b0;
            err_comp         <= 1'b0;
            err_cnt          <= '0;
            first_fail_cycle <= '0;
            cycle_cnt        <= '0;
            done             <= 1'b0;
            pass             <= 1'b0;
        end else begin
            hold_cnt         <= nxt_hold;
            err_q            <= nxt_err_q;
            err_qb           <= nxt_err_qb;
            err_comp         <= nxt_err_comp;
            err_cnt          <= nxt_err_cnt;
            first_fail_cycle <= nxt_ffc;
            cycle_cnt        <= nxt_cycle;
            done             <= nxt_done;
            pass             <= nxt_pass;
        end
    end

endmodule
